// File: rtl/latch_ctrl_pkg.sv
// Shared state encoding and width helpers for the latch bank write controller.
package latch_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSetup  = 3'd1,
      StEnable = 3'd2,
      StHold   = 3'd3,
      StAck    = 3'd4
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_width(input int unsigned v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 with wrap, one-hot grant.
module rr_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]            req,
   input  logic [idx_width(N)-1:0] last,
   output logic [N-1:0]            gnt
);

   localparam int unsigned LW = idx_width(N);

   logic          found;
   logic [LW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = LW'((32'(last) + k) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a shared gated-latch bank: arbitrates requesters and runs a
// setup / enable / hold sequence per write with fully registered outputs.
module latch_bank_ctrl
   import latch_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned EN_CYC    = 2,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic [N_REQ-1:0]                 Req,
   input  logic [N_REQ*clog2(DEPTH)-1:0]    ReqAddr,
   input  logic [N_REQ*WIDTH-1:0]           ReqData,
   output logic [N_REQ-1:0]                 Ack,
   output logic [N_REQ-1:0]                 Grant,
   output logic [WIDTH-1:0]                 LatchD,
   output logic [DEPTH-1:0]                 LatchEn,
   output logic                             Busy
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned LW = idx_width(N_REQ);
   localparam int unsigned CW = max3(SETUP_CYC, EN_CYC, HOLD_CYC);

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [LW-1:0]    last;
   logic [LW-1:0]    gidx;
   logic [AW-1:0]    addr;
   logic [N_REQ-1:0] gnt;
   logic [LW-1:0]    win_idx;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_data;
   logic [DEPTH-1:0] en_dec;

   rr_arbiter #(
      .N(N_REQ)
   ) u_arb (
      .req (Req),
      .last(last),
      .gnt (gnt)
   );

   always_comb begin
      win_idx  = '0;
      win_addr = '0;
      win_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            win_idx  = LW'(i);
            win_addr = ReqAddr[i*AW +: AW];
            win_data = ReqData[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      en_dec = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         en_dec[k] = (32'(addr) == k);
      end
   end

   // Outputs are set on the edge entering each phase, so LatchD only moves while
   // LatchEn is low (grant edge and return to idle).
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= StIdle;
         cnt     <= '0;
         last    <= LW'(N_REQ - 1);
         gidx    <= '0;
         addr    <= '0;
         Grant   <= '0;
         Ack     <= '0;
         LatchD  <= '0;
         LatchEn <= '0;
         Busy    <= 1'b0;
      end else begin
         Ack <= '0;
         case (state)
            StIdle: begin
               if (|Req) begin
                  Grant  <= gnt;
                  gidx   <= win_idx;
                  addr   <= win_addr;
                  LatchD <= win_data;
                  Busy   <= 1'b1;
                  cnt    <= CW'(SETUP_CYC - 1);
                  state  <= StSetup;
               end
            end
            StSetup: begin
               if (cnt == '0) begin
                  LatchEn <= en_dec;
                  cnt     <= CW'(EN_CYC - 1);
                  state   <= StEnable;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StEnable: begin
               if (cnt == '0) begin
                  LatchEn <= '0;
                  cnt     <= CW'(HOLD_CYC - 1);
                  state   <= StHold;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StHold: begin
               if (cnt == '0) begin
                  Ack   <= Grant;
                  state <= StAck;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StAck: begin
               last   <= gidx;
               Grant  <= '0;
               LatchD <= '0;
               Busy   <= 1'b0;
               state  <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: timeline model of each write plus directed literal checks.
module tb_latch_bank_ctrl;

   localparam int N = 4;
   localparam int W = 8;
   localparam int AWB = 2;
   localparam int S = 1;
   localparam int E = 2;
   localparam int H = 1;

   logic        clk, rst_n;
   logic [3:0]  req_a, ack_a, grant_a, en_a;
   logic [3:0]  req_b, ack_b, grant_b, en_b;
   logic [7:0]  addr_a, addr_b, d_a, d_b;
   logic [31:0] data_a, data_b;
   logic        busy_a, busy_b;

   int          nchecks, nerrors, cyc;
   logic [3:0]  rearm;
   logic [7:0]  prev_d;
   logic [3:0]  prev_en, prev_grant;
   int          glog[$];
   int          gcyc[$];

   bit          m_busy;
   int          m_t, m_g, m_addr, m_last;
   logic [7:0]  m_data;

   latch_bank_ctrl dut_a (
      .Clk    (clk),
      .Reset_n(rst_n),
      .Req    (req_a),
      .ReqAddr(addr_a),
      .ReqData(data_a),
      .Ack    (ack_a),
      .Grant  (grant_a),
      .LatchD (d_a),
      .LatchEn(en_a),
      .Busy   (busy_a)
   );

   latch_bank_ctrl #(
      .SETUP_CYC(2),
      .EN_CYC   (3),
      .HOLD_CYC (2)
   ) dut_b (
      .Clk    (clk),
      .Reset_n(rst_n),
      .Req    (req_b),
      .ReqAddr(addr_b),
      .ReqData(data_b),
      .Ack    (ack_b),
      .Grant  (grant_b),
      .LatchD (d_b),
      .LatchEn(en_b),
      .Busy   (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // A write is a timeline: t counts edges since the grant edge.
   task automatic model_update();
      if (!rst_n) begin
         m_busy = 1'b0;
         m_t    = 0;
         m_last = N - 1;
      end else if (!m_busy) begin
         if (req_a != 4'd0) begin
            for (int k = 1; k <= N; k++) begin
               int idx;
               idx = (m_last + k) % N;
               if (!m_busy && req_a[idx]) begin
                  m_g    = idx;
                  m_busy = 1'b1;
               end
            end
            m_addr = int'(addr_a[m_g*AWB +: AWB]);
            m_data = data_a[m_g*W +: W];
            m_t    = 0;
         end
      end else begin
         m_t++;
         if (m_t > S + E + H) begin
            m_busy = 1'b0;
            m_last = m_g;
         end
      end
   endtask

   task automatic step();
      logic [3:0] e_g, e_a, e_en;
      logic [7:0] e_d;
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      e_g = '0; e_a = '0; e_en = '0; e_d = '0;
      if (m_busy) begin
         e_g[m_g] = 1'b1;
         e_d      = m_data;
         if (m_t >= S && m_t < S + E) e_en[m_addr] = 1'b1;
         if (m_t == S + E + H) e_a[m_g] = 1'b1;
      end
      chk("m_grant", 32'(grant_a), 32'(e_g));
      chk("m_ack", 32'(ack_a), 32'(e_a));
      chk("m_latchd", 32'(d_a), 32'(e_d));
      chk("m_latchen", 32'(en_a), 32'(e_en));
      chk("m_busy", 32'(busy_a), 32'(m_busy));
      if (rst_n && (en_a != 4'd0 || prev_en != 4'd0)) chk("d_stable", 32'(d_a), 32'(prev_d));
      if (grant_a != 4'd0 && prev_grant == 4'd0) begin
         glog.push_back(oh_idx(grant_a));
         gcyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
         if (ack_a[i]) req_a[i] = 1'b0;
         else if (rearm[i] && !req_a[i]) req_a[i] = 1'b1;
      end
      prev_d     = d_a;
      prev_en    = en_a;
      prev_grant = grant_a;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = '0;
      rearm = '0;
      step();
      step();
      rst_n = 1'b1;
      glog.delete();
      gcyc.delete();
   endtask

   task automatic run_until_idle(input int limit, input string name);
      int n;
      n = 0;
      while (!(req_a == 4'd0 && busy_a == 1'b0) && n < limit) begin
         step();
         n++;
      end
      chk(name, 32'(req_a == 4'd0 && busy_a == 1'b0), 32'd1);
   endtask

   initial begin
      nchecks = 0; nerrors = 0; cyc = 0;
      rst_n = 1'b0; rearm = '0;
      req_a = '0; addr_a = '0; data_a = '0;
      req_b = '0; addr_b = '0; data_b = '0;
      prev_d = '0; prev_en = '0; prev_grant = '0;
      m_busy = 1'b0; m_t = 0; m_g = 0; m_addr = 0; m_last = N - 1; m_data = '0;

      // Reset state and basic write timeline.
      step();
      step();
      chk("rst_grant", 32'(grant_a), 32'h0);
      chk("rst_ack", 32'(ack_a), 32'h0);
      chk("rst_latchd", 32'(d_a), 32'h0);
      chk("rst_latchen", 32'(en_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_busy_b", 32'(busy_b), 32'h0);
      rst_n = 1'b1;
      req_a = 4'b0001; addr_a = 8'h02; data_a = 32'h0000_00A5;
      step();
      chk("t1_grant", 32'(grant_a), 32'h1);
      chk("t1_d_e0", 32'(d_a), 32'hA5);
      chk("t1_en_e0", 32'(en_a), 32'h0);
      step();
      chk("t1_en_e1", 32'(en_a), 32'h4);
      step();
      chk("t1_en_e2", 32'(en_a), 32'h4);
      step();
      chk("t1_en_e3", 32'(en_a), 32'h0);
      chk("t1_d_e3", 32'(d_a), 32'hA5);
      step();
      chk("t1_ack_e4", 32'(ack_a), 32'h1);
      step();
      chk("t1_busy_e5", 32'(busy_a), 32'h0);
      chk("t1_d_e5", 32'(d_a), 32'h0);
      chk("t1_ack_e5", 32'(ack_a), 32'h0);

      // All four requesting at once.
      do_reset();
      addr_a = 8'b11_10_01_00; data_a = 32'h4433_2211;
      req_a  = 4'hF;
      run_until_idle(40, "s_done");
      chk("s_count", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4; i++) if (i < glog.size()) chk("s_order", 32'(glog[i]), 32'(i));
      for (int i = 1; i < 4; i++) if (i < gcyc.size()) chk("s_space", 32'(gcyc[i] - gcyc[i-1]), 32'd6);

      // Two requesters continuously re-raising.
      do_reset();
      addr_a = 8'h00; data_a = 32'h1234_5678;
      req_a  = 4'b0101; rearm = 4'b0101;
      repeat (24) step();
      rearm = '0;
      run_until_idle(30, "f_done");
      chk("f_count", 32'(glog.size() >= 4), 32'd1);
      for (int i = 0; i < glog.size(); i++) chk("f_alt", 32'(glog[i]), 32'((i % 2) ? 2 : 0));

      // Data captured at grant; later ReqData changes ignored.
      do_reset();
      addr_a = 8'h0C; data_a = 32'h0000_3C00;
      req_a  = 4'b0010;
      step(); step(); step();
      data_a = 32'h0000_C300;
      step(); step();
      chk("ds_ack", 32'(ack_a), 32'h2);
      chk("ds_d", 32'(d_a), 32'h3C);
      run_until_idle(5, "ds_done");

      // Reset during ENABLE also restores the round-robin pointer.
      do_reset();
      addr_a = 8'h10; data_a = 32'h0099_7700;
      req_a  = 4'b0010;
      run_until_idle(10, "rm_first");
      req_a = 4'b0100;
      step(); step();
      chk("rm_en_pre", 32'(en_a), 32'h2);
      rst_n = 1'b0;
      step();
      chk("rm_en", 32'(en_a), 32'h0);
      chk("rm_grant", 32'(grant_a), 32'h0);
      chk("rm_ack", 32'(ack_a), 32'h0);
      chk("rm_busy", 32'(busy_a), 32'h0);
      rst_n = 1'b1;
      req_a = 4'b0101;
      step();
      chk("rm_next", 32'(grant_a), 32'h1);
      run_until_idle(20, "rm_done");

      // Longer phases on the second instance: enable e2..e4, ack at e7.
      addr_b = 8'h01; data_b = 32'h0000_005A;
      req_b  = 4'b0001;
      for (int c = 0; c <= 8; c++) begin
         step();
         chk("cb_en", 32'(en_b), (c >= 2 && c <= 4) ? 32'h2 : 32'h0);
         chk("cb_ack", 32'(ack_b), (c == 7) ? 32'h1 : 32'h0);
         chk("cb_busy", 32'(busy_b), (c <= 7) ? 32'h1 : 32'h0);
         chk("cb_d", 32'(d_b), (c <= 7) ? 32'h5A : 32'h0);
         if (ack_b[0]) req_b = 4'b0000;
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
